// File: rtl/rca_4bit_adder.sv
// Registered ripple-carry adder: WIDTH full-adder stages feed the Sum/Cout output registers.
// Optional macro RCA_OVF_EN adds a registered two's-complement overflow flag (port Ovf).

module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_4bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
`ifdef RCA_OVF_EN
  output logic             Ovf,
`endif
  output logic             out_valid
);

  // Stage p0: combinational carry chain, carry_p0[i] is the carry into stage i
  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;

  assign carry_p0[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    rca_full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry_p0[i]),
      .s  (sum_p0[i]),
      .co (carry_p0[i+1])
    );
  end

  // Stage p1: output registers; reset wins over en
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        Sum  <= sum_p0;
        Cout <= carry_p0[WIDTH];
      end
    end
  end

`ifdef RCA_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Ovf <= 1'b0;
    end else if (en) begin
      Ovf <= carry_p0[WIDTH] ^ carry_p0[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_rca_4bit_adder.sv
// Self-checking bench for rca_4bit_adder: expectations queued at drive time, popped after the capture edge.

module tb_rca_4bit_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] a   = '0;
  logic [3:0] b   = '0;
  logic       cin = 1'b0;
  logic [3:0] sum;
  logic       cout;
  logic       out_valid;
`ifdef RCA_OVF_EN
  logic       ovf;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  rca_4bit_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .Sum       (sum),
    .Cout      (cout),
`ifdef RCA_OVF_EN
    .Ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference overflow: signed sum outside [-8, 7]
  function automatic logic model_ovf(input logic [3:0] x, input logic [3:0] y, input logic c);
    int r;
    r = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (r > 7) || (r < -8);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one enabled operand set and queue its expected result
  task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic c,
                       input logic [3:0] es, input logic ec);
    exp_t e;
    a   = x;
    b   = y;
    cin = c;
    en  = 1'b1;
    e.sum  = es;
    e.cout = ec;
    e.ovf  = model_ovf(x, y, c);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; a = 4'd15; b = 4'd15; cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({sum, cout, out_valid} !== 6'd0) begin
        fails++;
        $display("FAIL reset[%0d] sum=%0d cout=%b vld=%b required sum=0 cout=0 vld=0", i, sum, cout, out_valid);
      end
`ifdef RCA_OVF_EN
      tests++;
      if (ovf !== 1'b0) begin
        fails++;
        $display("FAIL reset_ovf[%0d] ovf=%b required 0", i, ovf);
      end
`endif
    end
    rst = 1'b0;
    en  = 1'b0;
    sb.delete();
  endtask

  task automatic test_table(input string name, input int n,
                            input logic [3:0] ta[4], input logic [3:0] tb[4], input logic tc[4],
                            input logic [3:0] ts[4], input logic tco[4]);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      drive(ta[i], tb[i], tc[i], ts[i], tco[i]);
      step();
      e = sb.pop_front();
      tests++;
      if (out_valid !== 1'b1 || sum !== e.sum || cout !== e.cout) begin
        fails++;
        $display("FAIL %s[%0d] %0d+%0d+%0d: sum=%0d cout=%b vld=%b required sum=%0d cout=%b vld=1",
                 name, i, ta[i], tb[i], tc[i], sum, cout, out_valid, e.sum, e.cout);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] ta[4], tb[4], ts[4];
    logic       tc[4], tco[4];
    ta = '{4'd5, 4'd6, 4'd0, 4'd0};  tb = '{4'd3, 4'd9, 4'd0, 4'd0};
    tc = '{1'b0, 1'b0, 1'b1, 1'b0};
    ts = '{4'd8, 4'd15, 4'd1, 4'd0}; tco = '{1'b0, 1'b0, 1'b0, 1'b0};
    test_table("basic", 3, ta, tb, tc, ts, tco);
  endtask

  task automatic test_carry();
    logic [3:0] ta[4], tb[4], ts[4];
    logic       tc[4], tco[4];
    ta = '{4'd9, 4'd8, 4'd15, 4'd15}; tb = '{4'd7, 4'd8, 4'd1, 4'd15};
    tc = '{1'b0, 1'b1, 1'b0, 1'b1};
    ts = '{4'd0, 4'd1, 4'd0, 4'd15};  tco = '{1'b1, 1'b1, 1'b1, 1'b1};
    test_table("carry", 4, ta, tb, tc, ts, tco);
  endtask

  task automatic test_hold();
    exp_t e;
    drive(4'd5, 4'd3, 1'b0, 4'd8, 1'b0);
    step();
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || sum !== e.sum || cout !== e.cout) begin
      fails++;
      $display("FAIL hold_load sum=%0d cout=%b vld=%b required sum=8 cout=0 vld=1", sum, cout, out_valid);
    end
    en = 1'b0; a = 4'd9; b = 4'd7;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b0 || sum !== 4'd8 || cout !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d] sum=%0d cout=%b vld=%b required sum=8 cout=0 vld=0", i, sum, cout, out_valid);
      end
`ifdef RCA_OVF_EN
      tests++;
      if (ovf !== 1'b1) begin
        fails++;
        $display("FAIL hold_ovf[%0d] ovf=%b required 1", i, ovf);
      end
`endif
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    drive(4'd15, 4'd15, 1'b1, 4'd15, 1'b1);
    step();
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || sum !== e.sum || cout !== e.cout) begin
      fails++;
      $display("FAIL prio_load sum=%0d cout=%b vld=%b required sum=15 cout=1 vld=1", sum, cout, out_valid);
    end
    rst = 1'b1; en = 1'b1; a = 4'd9; b = 4'd7; cin = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0 || sum !== 4'd0 || cout !== 1'b0) begin
      fails++;
      $display("FAIL reset_priority sum=%0d cout=%b vld=%b required sum=0 cout=0 vld=0", sum, cout, out_valid);
    end
    rst = 1'b0; en = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_vld vld=%b required 0", out_valid);
    end
  endtask

`ifdef RCA_OVF_EN
  task automatic test_overflow();
    logic [3:0] ta[4], tb[4];
    logic       tc[4], to[4];
    ta = '{4'd7, 4'd8, 4'd5, 4'd2}; tb = '{4'd1, 4'd8, 4'd3, 4'd3};
    tc = '{1'b0, 1'b0, 1'b0, 1'b0}; to = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      a = ta[i]; b = tb[i]; cin = tc[i]; en = 1'b1;
      step();
      tests++;
      if (ovf !== to[i]) begin
        fails++;
        $display("FAIL ovf[%0d] %0d+%0d: ovf=%b required %b", i, ta[i], tb[i], ovf, to[i]);
      end
    end
    tests++;
    a = 4'd8; b = 4'd8; cin = 1'b0;
    step();
    if (ovf !== 1'b1 || sum !== 4'd0 || cout !== 1'b1) begin
      fails++;
      $display("FAIL ovf_8p8 ovf=%b sum=%0d cout=%b required ovf=1 sum=0 cout=1", ovf, sum, cout);
    end
    en = 1'b0;
  endtask
`endif

  task automatic test_exhaustive();
    exp_t e;
    int   r;
    for (int i = 0; i < 512; i++) begin
      r = (i >> 5) + ((i >> 1) & 15) + (i & 1);
      drive(4'((i >> 5) & 15), 4'((i >> 1) & 15), 1'(i & 1), 4'(r & 15), 1'(r >> 4));
      step();
      e = sb.pop_front();
      tests++;
      if (out_valid !== 1'b1 || sum !== e.sum || cout !== e.cout) begin
        fails++;
        $display("FAIL sweep %0d+%0d+%0d: sum=%0d cout=%b vld=%b required sum=%0d cout=%b",
                 a, b, cin, sum, cout, out_valid, e.sum, e.cout);
      end
`ifdef RCA_OVF_EN
      tests++;
      if (ovf !== e.ovf) begin
        fails++;
        $display("FAIL sweep_ovf %0d+%0d+%0d: ovf=%b required %b", a, b, cin, ovf, e.ovf);
      end
`endif
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_hold();
    test_reset_priority();
`ifdef RCA_OVF_EN
    test_overflow();
`endif
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
